// File: rtl/cache_pkg.sv
// Shared request/state types for the LSU request buffer in front of the cache controller.
package cache_pkg;

    typedef enum logic {
        LSU_LOAD  = 1'b0,
        LSU_STORE = 1'b1
    } lsu_op_e;

    typedef struct packed {
        logic [31:0] addr;
        lsu_op_e     op;
    } lsu_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } lsu_state_e;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/lsu_req_fifo.sv
// Synchronous FIFO of lsu_req_t; head is visible combinationally so the issue stage can
// copy it into its own flops without an extra read cycle.
module lsu_req_fifo
    import cache_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  lsu_req_t                   push_data_i,
    input  logic                       pop_i,
    output lsu_req_t                   head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    lsu_req_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/lsu_req_buffer.sv
// Buffers core load/store requests and issues them one at a time to the cache controller.
// Optional misaligned-address rejection is enabled by defining LSU_ALIGN_CHECK_EN.
module lsu_req_buffer
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          core_req_valid,
    output logic                          core_req_ready,
    input  logic [31:0]                   core_req_addr,
    input  logic                          core_req_store,
    output logic                          core_rsp_valid,
    input  logic                          core_rsp_ready,
    output logic [DATA_WIDTH-1:0]         core_rsp_data,
    output logic                          core_rsp_err,
    output logic [31:0]                   address,
    output logic                          lsu_operator,
    output logic                          mem_enable,
    input  logic                          stall,
    input  logic [DATA_WIDTH-1:0]         read_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    lsu_state_e            state_q, state_d;
    lsu_req_t              head, push_req;
    logic                  fifo_full, fifo_empty;
    logic                  fifo_push, fifo_pop;
    logic                  load_head, head_bad;

    logic [31:0]           addr_q, addr_d;
    lsu_op_e               op_q, op_d;
    logic                  mem_en_q, mem_en_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
`ifdef LSU_ALIGN_CHECK_EN
    logic                  rsp_err_q, rsp_err_d;
`endif

    assign push_req  = '{addr: core_req_addr, op: lsu_op_e'(core_req_store)};
    assign fifo_push = core_req_valid & ~fifo_full;

    lsu_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (push_req),
        .pop_i       (fifo_pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

`ifdef LSU_ALIGN_CHECK_EN
    assign head_bad = is_misaligned(head.addr);
`else
    assign head_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The entry stays in the FIFO while in flight; it is popped only on completion
    // (or immediately when rejected as misaligned).
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        op_d       = op_q;
        mem_en_d   = mem_en_q;
        rsp_data_d = rsp_data_q;
`ifdef LSU_ALIGN_CHECK_EN
        rsp_err_d  = rsp_err_q;
`endif
        fifo_pop   = 1'b0;
        load_head  = 1'b0;
        case (state_q)
            IDLE: begin
                load_head = ~fifo_empty;
            end
            ISSUE: begin
                if (mem_en_q && !stall) begin
                    rsp_data_d = (op_q == LSU_STORE) ? '0 : read_data;
`ifdef LSU_ALIGN_CHECK_EN
                    rsp_err_d  = 1'b0;
`endif
                    mem_en_d   = 1'b0;
                    fifo_pop   = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (core_rsp_ready) begin
                    state_d   = IDLE;
                    load_head = ~fifo_empty;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_head) begin
            addr_d = head.addr;
            op_d   = head.op;
            if (head_bad) begin
                fifo_pop   = 1'b1;
                rsp_data_d = '0;
`ifdef LSU_ALIGN_CHECK_EN
                rsp_err_d  = 1'b1;
`endif
                state_d    = RESP;
            end else begin
                mem_en_d = 1'b1;
                state_d  = ISSUE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            op_q       <= LSU_LOAD;
            mem_en_q   <= 1'b0;
            rsp_data_q <= '0;
`ifdef LSU_ALIGN_CHECK_EN
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            addr_q     <= addr_d;
            op_q       <= op_d;
            mem_en_q   <= mem_en_d;
            rsp_data_q <= rsp_data_d;
`ifdef LSU_ALIGN_CHECK_EN
            rsp_err_q  <= rsp_err_d;
`endif
        end
    end

    always_comb begin
        core_req_ready = ~fifo_full;
        core_rsp_valid = (state_q == RESP);
        core_rsp_data  = rsp_data_q;
`ifdef LSU_ALIGN_CHECK_EN
        core_rsp_err   = rsp_err_q;
`else
        core_rsp_err   = 1'b0;
`endif
        address        = addr_q;
        lsu_operator   = op_q;
        mem_enable     = mem_en_q;
    end

endmodule

// File: tb/tb_lsu_req_buffer.sv
// Directed bench for lsu_req_buffer: a transaction-level queue model checked every cycle,
// plus literal expectations for hit latency, miss hold, full FIFO, backpressure and reset.
module tb_lsu_req_buffer;

    localparam int DW    = 11;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_req_valid, core_req_ready, core_req_store;
    logic [31:0]   core_req_addr;
    logic          core_rsp_valid, core_rsp_ready, core_rsp_err;
    logic [DW-1:0] core_rsp_data;
    logic [31:0]   address;
    logic          lsu_operator, mem_enable, stall;
    logic [DW-1:0] read_data;
    logic [2:0]    fifo_count;

    lsu_req_buffer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .core_req_valid (core_req_valid),
        .core_req_ready (core_req_ready),
        .core_req_addr  (core_req_addr),
        .core_req_store (core_req_store),
        .core_rsp_valid (core_rsp_valid),
        .core_rsp_ready (core_rsp_ready),
        .core_rsp_data  (core_rsp_data),
        .core_rsp_err   (core_rsp_err),
        .address        (address),
        .lsu_operator   (lsu_operator),
        .mem_enable     (mem_enable),
        .stall          (stall),
        .read_data      (read_data),
        .fifo_count     (fifo_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Model: a queue of pending requests; the head is either waiting, at the cache, or
    // already answered and waiting for the core to take the response.
    typedef struct packed { logic [31:0] addr; logic st; } mreq_t;
    mreq_t      mq[$];
    mreq_t      m_cur, m_new;
    bit         m_busy, m_have, m_err, m_acc, m_comp, m_hs;
    logic [DW-1:0] m_data;

    function automatic bit m_bad(input logic [31:0] a);
`ifdef LSU_ALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_busy = 0; m_have = 0; m_err = 0; m_data = '0; m_cur = '0;
        end else begin
            m_acc  = core_req_valid && (mq.size() < DEPTH);
            m_new  = '{addr: core_req_addr, st: core_req_store};
            m_comp = m_busy && !stall;
            m_hs   = m_have && core_rsp_ready;
            if (m_comp) begin
                m_data = m_cur.st ? '0 : read_data;
                m_err  = 0;
                void'(mq.pop_front());
                m_busy = 0;
                m_have = 1;
            end else if ((!m_busy && !m_have) || m_hs) begin
                m_have = 0;
                if (mq.size() > 0) begin
                    if (m_bad(mq[0].addr)) begin
                        m_data = '0;
                        m_err  = 1;
                        void'(mq.pop_front());
                        m_have = 1;
                    end else begin
                        m_cur  = mq[0];
                        m_busy = 1;
                    end
                end
            end
            if (m_acc) mq.push_back(m_new);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_count", 32'(fifo_count), 32'(mq.size()));
            chk("m_ready", 32'(core_req_ready), 32'(mq.size() < DEPTH));
            chk("m_mem_en", 32'(mem_enable), 32'(m_busy));
            if (m_busy) begin
                chk("m_addr", address, m_cur.addr);
                chk("m_op", 32'(lsu_operator), 32'(m_cur.st));
            end
            chk("m_rsp_valid", 32'(core_rsp_valid), 32'(m_have));
            if (m_have) begin
                chk("m_rsp_data", 32'(core_rsp_data), 32'(m_data));
                chk("m_rsp_err", 32'(core_rsp_err), 32'(m_err));
            end
        end
    end

    logic [DW:0] rsp_log[$];
    always @(posedge clk) begin
        if (!rst && core_rsp_valid && core_rsp_ready) begin
            rsp_log.push_back({core_rsp_err, core_rsp_data});
            $display("rsp: err=%0b data=0x%0h", core_rsp_err, core_rsp_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic st);
        core_req_valid = 1'b1;
        core_req_addr  = a;
        core_req_store = st;
        tick();
        core_req_valid = 1'b0;
    endtask

    initial begin
        bit done;
        rst = 1'b1;
        core_req_valid = 0; core_req_addr = '0; core_req_store = 0;
        core_rsp_ready = 1; stall = 0; read_data = '0;
        repeat (2) tick();
        chk("rst_ready", 32'(core_req_ready), 1);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_mem_en", 32'(mem_enable), 0);
        chk("rst_rsp_valid", 32'(core_rsp_valid), 0);
        rst = 1'b0;
        tick();

        // Load hit: enqueue at N, mem_enable at N+2, response at N+3.
        read_data = 11'h2A5;
        push(32'h100, 1'b0);
        chk("hit_count", 32'(fifo_count), 1);
        chk("hit_mem_en_early", 32'(mem_enable), 0);
        tick();
        chk("hit_mem_en", 32'(mem_enable), 1);
        chk("hit_addr", address, 32'h100);
        tick();
        chk("hit_rsp_valid", 32'(core_rsp_valid), 1);
        chk("hit_rsp_data", 32'(core_rsp_data), 32'h2A5);
        chk("hit_rsp_err", 32'(core_rsp_err), 0);
        tick();
        chk("hit_rsp_done", 32'(core_rsp_valid), 0);

        // Miss: stall held for 10 cycles.
        rsp_log.delete();
        stall = 1'b1;
        push(32'h2000, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("miss_mem_en", 32'(mem_enable), 1);
            chk("miss_addr", address, 32'h2000);
            chk("miss_op", 32'(lsu_operator), 0);
            chk("miss_no_rsp", 32'(core_rsp_valid), 0);
            tick();
        end
        stall = 1'b0;
        read_data = 11'h155;
        tick();
        chk("miss_rsp_data", 32'(core_rsp_data), 32'h155);
        repeat (4) tick();
        chk("miss_one_rsp", 32'(rsp_log.size()), 1);

        // Full: five pushes under stall, only four accepted.
        rsp_log.delete();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            core_req_valid = 1'b1;
            core_req_addr  = 32'h40 + 32'(4 * i);
            core_req_store = i[0];
            tick();
            if (i == 3) chk("full_ready", 32'(core_req_ready), 0);
        end
        core_req_valid = 1'b0;
        chk("full_count", 32'(fifo_count), 4);
        stall = 1'b0;
        read_data = 11'h0AB;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            done = (rsp_log.size() >= 4);
        end
        chk("full_drain", 32'(rsp_log.size()), 4);
        if (rsp_log.size() >= 4) begin
            chk("full_rsp0", 32'(rsp_log[0]), 32'h0AB);
            chk("full_rsp1", 32'(rsp_log[1]), 32'h000);
            chk("full_rsp2", 32'(rsp_log[2]), 32'h0AB);
            chk("full_rsp3", 32'(rsp_log[3]), 32'h000);
        end
        repeat (2) tick();

        // Backpressure: response held, next request waits for the handshake.
        core_rsp_ready = 1'b0;
        read_data = 11'h111;
        push(32'h300, 1'b0);
        push(32'h304, 1'b0);
        tick();
        read_data = 11'h222;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(core_rsp_valid), 1);
            chk("bp_rsp_data", 32'(core_rsp_data), 32'h111);
            chk("bp_mem_en", 32'(mem_enable), 0);
            tick();
        end
        core_rsp_ready = 1'b1;
        tick();
        chk("bp_next_issue", 32'(mem_enable), 1);
        chk("bp_next_addr", address, 32'h304);
        tick();
        chk("bp_next_data", 32'(core_rsp_data), 32'h222);
        repeat (2) tick();

        // Misaligned address.
        read_data = 11'h7FF;
        push(32'h103, 1'b0);
`ifdef LSU_ALIGN_CHECK_EN
        chk("mis_mem_en", 32'(mem_enable), 0);
        chk("mis_rsp_valid", 32'(core_rsp_valid), 1);
        chk("mis_rsp_err", 32'(core_rsp_err), 1);
        chk("mis_rsp_data", 32'(core_rsp_data), 0);
        tick();
        chk("mis_no_issue", 32'(mem_enable), 0);
`else
        tick();
        chk("mis_mem_en", 32'(mem_enable), 1);
        chk("mis_addr", address, 32'h103);
        tick();
        chk("mis_rsp_data", 32'(core_rsp_data), 32'h7FF);
        chk("mis_rsp_err", 32'(core_rsp_err), 0);
`endif
        repeat (3) tick();

        // Reset mid-issue: outputs drop immediately.
        stall = 1'b1;
        push(32'h500, 1'b0);
        push(32'h504, 1'b1);
        tick();
        chk("rst2_pre_mem_en", 32'(mem_enable), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst2_mem_en", 32'(mem_enable), 0);
        chk("rst2_rsp_valid", 32'(core_rsp_valid), 0);
        chk("rst2_count", 32'(fifo_count), 0);
        chk("rst2_ready", 32'(core_req_ready), 1);
        tick();
        rst = 1'b0;
        stall = 1'b0;
        repeat (2) tick();
        chk("rst2_after_mem_en", 32'(mem_enable), 0);
        chk("rst2_after_count", 32'(fifo_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
